// File: rtl/sarray_pkg.sv
// Shared definitions for the systolic array result path: default widths,
// the drain FSM state encoding and the result row record.
package sarray_pkg;

    localparam int DEFAULT_STORE_W = 1024;
    localparam int DEFAULT_CNT_W   = 8;
    localparam int DEFAULT_ROWS    = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TRIG    = 2'd1,
        ST_COLLECT = 2'd2,
        ST_FLUSH   = 2'd3
    } drain_state_e;

    typedef struct packed {
        logic [DEFAULT_CNT_W-1:0]   cnt;
        logic [DEFAULT_STORE_W-1:0] data;
    } row_t;

endpackage

// File: rtl/sarray_drain_fifo.sv
// Small synchronous FIFO buffering result rows between the array and the
// write port; a push into a full FIFO is taken when a pop happens that cycle.
module sarray_drain_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign data_o  = mem_q[rd_ptr_q];

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is not reset; count_q alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/sarray_drain.sv
// Drain side of the systolic array: triggers store-C, buffers the result rows
// and writes them out row by row, flagging tag, overflow and stray errors.
module sarray_drain
    import sarray_pkg::*;
#(
    parameter int STORE_W    = DEFAULT_STORE_W,
    parameter int CNT_W      = DEFAULT_CNT_W,
    parameter int ROWS       = DEFAULT_ROWS,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [CNT_W-1:0]   cmd_cnt_i,
    input  logic [ADDR_W-1:0]  cmd_base_i,
    input  logic [ADDR_W-1:0]  cmd_stride_i,
    output logic               storec_valid_o,
    input  logic               bot_valid_i,
    input  logic [CNT_W-1:0]   bot_cnt_i,
    input  logic [STORE_W-1:0] bot_data_i,
    output logic               wr_valid_o,
    input  logic               wr_ready_i,
    output logic [ADDR_W-1:0]  wr_addr_o,
    output logic [STORE_W-1:0] wr_data_o,
    output logic               done_o,
    output logic               err_cnt_o,
    output logic               err_ovf_o,
    output logic               err_stray_o
);

    localparam int              CW       = $clog2(ROWS + 1);
    localparam int              FW       = ADDR_W + STORE_W;
    localparam logic [CW-1:0]   ROWS_C   = CW'(ROWS);
    localparam logic [CW-1:0]   LAST_ROW = CW'(ROWS - 1);

    drain_state_e        state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   stride_q, stride_d;
    logic [ADDR_W-1:0]   slot_addr_q, slot_addr_d;
    logic [CW-1:0]       rx_cnt_q, rx_cnt_d;
    logic [CW-1:0]       wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]       drop_cnt_q, drop_cnt_d;
    logic                err_cnt_q, err_cnt_d;
    logic                err_ovf_q, err_ovf_d;
    logic                err_stray_q, err_stray_d;

    logic                cmd_fire, row_in, last_row_in, stray_in;
    logic                fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
    logic                flush_done;
    logic [FW-1:0]       fifo_dout;
    logic [ADDR_W-1:0]   head_addr;
    logic [STORE_W-1:0]  head_data;

    // Each row is queued with its own slot address so dropped rows leave gaps.
    sarray_drain_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .data_i  ({slot_addr_q, bot_data_i}),
        .pop_i   (fifo_pop),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign {head_addr, head_data} = fifo_dout;

    always_comb begin
        cmd_fire    = cmd_valid_i && cmd_ready_q;
        row_in      = bot_valid_i && ((state_q == ST_TRIG) || (state_q == ST_COLLECT));
        stray_in    = bot_valid_i && ((state_q == ST_IDLE) || (state_q == ST_FLUSH));
        last_row_in = row_in && (rx_cnt_q == LAST_ROW);
        fifo_pop    = !fifo_empty && wr_ready_i;
        fifo_push   = row_in && (!fifo_full || fifo_pop);
        drop        = row_in && !fifo_push;
        flush_done  = fifo_empty && (wr_cnt_q == ROWS_C - drop_cnt_q);
    end

    always_comb begin : next_state
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:             if (cmd_fire) state_d = ST_TRIG;
            ST_TRIG, ST_COLLECT: state_d = last_row_in ? ST_FLUSH : ST_COLLECT;
            ST_FLUSH:            if (flush_done) state_d = ST_IDLE;
            default:             state_d = ST_IDLE;
        endcase
    end

    always_comb begin : fsm_outputs
        storec_valid_o = (state_q == ST_TRIG);
        done_o         = (state_q == ST_FLUSH) && flush_done;
    end

    always_comb begin : datapath_next
        cmd_ready_d = (state_d == ST_IDLE);
        cnt_d       = cnt_q;
        stride_d    = stride_q;
        slot_addr_d = slot_addr_q;
        rx_cnt_d    = rx_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_ovf_d   = err_ovf_q;
        err_stray_d = err_stray_q;
        if (cmd_fire) begin
            cnt_d       = cmd_cnt_i;
            stride_d    = cmd_stride_i;
            slot_addr_d = cmd_base_i;
            rx_cnt_d    = '0;
            wr_cnt_d    = '0;
            drop_cnt_d  = '0;
            err_cnt_d   = 1'b0;
            err_ovf_d   = 1'b0;
            err_stray_d = 1'b0;
        end else begin
            if (row_in) begin
                rx_cnt_d    = rx_cnt_q + CW'(1);
                slot_addr_d = slot_addr_q + stride_q;
                if (bot_cnt_i != cnt_q) err_cnt_d = 1'b1;
            end
            if (drop) begin
                drop_cnt_d = drop_cnt_q + CW'(1);
                err_ovf_d  = 1'b1;
            end
            if (fifo_pop) wr_cnt_d = wr_cnt_q + CW'(1);
        end
        if (stray_in) err_stray_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            cnt_q       <= '0;
            stride_q    <= '0;
            slot_addr_q <= '0;
            rx_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            drop_cnt_q  <= '0;
            err_cnt_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_stray_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            cnt_q       <= cnt_d;
            stride_q    <= stride_d;
            slot_addr_q <= slot_addr_d;
            rx_cnt_q    <= rx_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_ovf_q   <= err_ovf_d;
            err_stray_q <= err_stray_d;
        end
    end

    // Stale FIFO contents never leak onto the write bus while it is idle.
    assign cmd_ready_o = cmd_ready_q;
    assign wr_valid_o  = !fifo_empty;
    assign wr_addr_o   = fifo_empty ? '0 : head_addr;
    assign wr_data_o   = fifo_empty ? '0 : head_data;
    assign err_cnt_o   = err_cnt_q;
    assign err_ovf_o   = err_ovf_q;
    assign err_stray_o = err_stray_q;

endmodule

// File: tb/tb_sarray_drain.sv
// Directed self-checking bench for sarray_drain: one task per scenario,
// writes captured on the falling edge and compared against hand-derived slots.
module tb_sarray_drain;
    import sarray_pkg::*;

    localparam int STORE_W = DEFAULT_STORE_W;
    localparam int CNT_W   = DEFAULT_CNT_W;
    localparam int ADDR_W  = 32;

    logic               clk;
    logic               rst_n;
    logic               cmd_valid_i;
    logic               cmd_ready_o;
    logic [CNT_W-1:0]   cmd_cnt_i;
    logic [ADDR_W-1:0]  cmd_base_i;
    logic [ADDR_W-1:0]  cmd_stride_i;
    logic               storec_valid_o;
    logic               bot_valid_i;
    logic [CNT_W-1:0]   bot_cnt_i;
    logic [STORE_W-1:0] bot_data_i;
    logic               wr_valid_o;
    logic               wr_ready_i;
    logic [ADDR_W-1:0]  wr_addr_o;
    logic [STORE_W-1:0] wr_data_o;
    logic               done_o;
    logic               err_cnt_o;
    logic               err_ovf_o;
    logic               err_stray_o;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [STORE_W-1:0] data;
    } wr_t;

    wr_t                wr_q[$];
    int                 checks = 0;
    int                 errors = 0;
    int                 done_seen = 0;
    int                 storec_seen = 0;
    bit                 stall_q = 1'b0;
    logic [ADDR_W-1:0]  stall_addr;
    logic [STORE_W-1:0] stall_data;

    sarray_drain #(
        .STORE_W    (STORE_W),
        .CNT_W      (CNT_W),
        .ROWS       (64),
        .FIFO_DEPTH (4),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_cnt_i      (cmd_cnt_i),
        .cmd_base_i     (cmd_base_i),
        .cmd_stride_i   (cmd_stride_i),
        .storec_valid_o (storec_valid_o),
        .bot_valid_i    (bot_valid_i),
        .bot_cnt_i      (bot_cnt_i),
        .bot_data_i     (bot_data_i),
        .wr_valid_o     (wr_valid_o),
        .wr_ready_i     (wr_ready_i),
        .wr_addr_o      (wr_addr_o),
        .wr_data_o      (wr_data_o),
        .done_o         (done_o),
        .err_cnt_o      (err_cnt_o),
        .err_ovf_o      (err_ovf_o),
        .err_stray_o    (err_stray_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [STORE_W-1:0] row_data(input int seed, input int slot);
        logic [STORE_W-1:0] d;
        for (int i = 0; i < STORE_W / 32; i++) d[i*32 +: 32] = {seed[7:0], slot[7:0], i[15:0]};
        return d;
    endfunction

    // Falling-edge monitor: records handshakes, pulses, and checks stalled writes stay put.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                checks++;
                if (wr_valid_o !== 1'b1 || wr_addr_o !== stall_addr || wr_data_o !== stall_data) begin
                    errors++;
                    $display("FAIL hold_stable: valid %b addr %h, required valid 1 addr %h", wr_valid_o, wr_addr_o, stall_addr);
                end
            end
            stall_q    = wr_valid_o && !wr_ready_i;
            stall_addr = wr_addr_o;
            stall_data = wr_data_o;
            if (wr_valid_o && wr_ready_i) wr_q.push_back('{wr_addr_o, wr_data_o});
            if (done_o) done_seen++;
            if (storec_valid_o) storec_seen++;
        end
    end

    task automatic clear_obs();
        wr_q.delete();
        done_seen   = 0;
        storec_seen = 0;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic do_cmd(input logic [7:0] tag, input logic [31:0] base, input logic [31:0] stride, output bit ok);
        cmd_cnt_i    = tag;
        cmd_base_i   = base;
        cmd_stride_i = stride;
        cmd_valid_i  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready_o === 1'b1) ok = 1'b1;
        end
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
    endtask

    // Streams rows one per 'gap' cycles until done_o is seen or 'limit' cycles pass.
    task automatic drive_tile(input int seed, input logic [7:0] tag, input int nrows, input int gap,
                              input bit toggle, input int ready_off, input int bad_row,
                              input int cmd_row, input int limit);
        int  row = 0;
        int  c = 0;
        bit  fin = 1'b0;
        while (!fin && c < limit) begin
            if (row < nrows && (c % gap) == 0) begin
                bot_valid_i = 1'b1;
                bot_cnt_i   = (row == bad_row) ? tag + 8'd1 : tag;
                bot_data_i  = row_data(seed, row);
                row++;
            end else begin
                bot_valid_i = 1'b0;
                bot_data_i  = '0;
            end
            wr_ready_i = toggle ? c[0] : (c >= ready_off);
            if (cmd_row >= 0 && row > cmd_row) cmd_valid_i = 1'b1;
            @(negedge clk);
            if (done_o === 1'b1) fin = 1'b1;
            @(posedge clk); #1;
            c++;
        end
        bot_valid_i = 1'b0;
        wr_ready_i  = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid_i = 1'b0; cmd_cnt_i = '0; cmd_base_i = '0; cmd_stride_i = '0;
        bot_valid_i = 1'b0; bot_cnt_i = '0; bot_data_i = '0; wr_ready_i = 1'b1;
        #22;
        checks++;
        if ({cmd_ready_o, storec_valid_o, wr_valid_o, wr_addr_o, wr_data_o, done_o, err_cnt_o, err_ovf_o, err_stray_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready %b storec %b wr_valid %b done %b errs %b%b%b, required all 0",
                     cmd_ready_o, storec_valid_o, wr_valid_o, done_o, err_cnt_o, err_ovf_o, err_stray_o);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (cmd_ready_o !== 1'b1 || wr_valid_o !== 1'b0 || storec_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: ready %b wr_valid %b storec %b, required 1 0 0", cmd_ready_o, wr_valid_o, storec_valid_o);
        end
    endtask

    task automatic test_basic();
        bit ok;
        logic [31:0] exp_a;
        clear_obs();
        do_cmd(8'd5, 32'h1000, 32'h80, ok);
        checks++;
        if (!ok || storec_valid_o !== 1'b1) begin
            errors++; $display("FAIL basic_storec: accepted %0d storec %b, required 1 1", ok, storec_valid_o);
        end
        drive_tile(1, 8'd5, 64, 1, 1'b0, 0, -1, -1, 400);
        checks++;
        if (done_seen != 1 || storec_seen != 1) begin
            errors++; $display("FAIL basic_pulses: done %0d storec %0d, required 1 1", done_seen, storec_seen);
        end
        checks++;
        if ({err_cnt_o, err_ovf_o, err_stray_o} !== 3'b000) begin
            errors++; $display("FAIL basic_errs: %b%b%b, required 000", err_cnt_o, err_ovf_o, err_stray_o);
        end
        checks++;
        if (wr_q.size() != 64) begin
            errors++; $display("FAIL basic_count: %0d writes, required 64", wr_q.size());
        end
        if (wr_q.size() > 0) begin
            checks++;
            if (wr_q[0].addr !== 32'h1000 || wr_q[wr_q.size()-1].addr !== 32'h2F80) begin
                errors++; $display("FAIL basic_span: %h..%h, required 00001000..00002f80", wr_q[0].addr, wr_q[wr_q.size()-1].addr);
            end
        end
        for (int i = 0; i < wr_q.size() && i < 64; i++) begin
            exp_a = 32'h1000 + 32'(i) * 32'h80;
            checks++;
            if (wr_q[i].addr !== exp_a || wr_q[i].data !== row_data(1, i)) begin
                errors++; $display("FAIL basic_write[%0d]: addr %h data %h, required addr %h data %h",
                                   i, wr_q[i].addr, wr_q[i].data[31:0], exp_a, row_data(1, i) & 1024'hFFFF_FFFF);
            end
        end
    endtask

    task automatic test_throttled();
        bit ok;
        logic [31:0] exp_a;
        clear_obs();
        do_cmd(8'd5, 32'h1000, 32'h80, ok);
        drive_tile(2, 8'd5, 64, 2, 1'b1, 0, -1, -1, 400);
        checks++;
        if (!ok || done_seen != 1 || err_ovf_o !== 1'b0 || wr_q.size() != 64) begin
            errors++; $display("FAIL throttle_summary: accepted %0d done %0d ovf %b writes %0d, required 1 1 0 64",
                               ok, done_seen, err_ovf_o, wr_q.size());
        end
        for (int i = 0; i < wr_q.size() && i < 64; i++) begin
            exp_a = 32'h1000 + 32'(i) * 32'h80;
            checks++;
            if (wr_q[i].addr !== exp_a || wr_q[i].data !== row_data(2, i)) begin
                errors++; $display("FAIL throttle_write[%0d]: addr %h data %h, required addr %h", i, wr_q[i].addr, wr_q[i].data[31:0], exp_a);
            end
        end
    endtask

    // Ready low for the first 10 row cycles: rows 0-3 fill the FIFO, rows 4-9 are lost.
    task automatic test_overflow();
        bit ok;
        int slot;
        logic [31:0] exp_a;
        clear_obs();
        do_cmd(8'd5, 32'h1000, 32'h80, ok);
        drive_tile(3, 8'd5, 64, 1, 1'b0, 10, -1, -1, 400);
        checks++;
        if (!ok || done_seen != 1 || err_ovf_o !== 1'b1 || err_cnt_o !== 1'b0) begin
            errors++; $display("FAIL ovf_flags: accepted %0d done %0d ovf %b cnt %b, required 1 1 1 0", ok, done_seen, err_ovf_o, err_cnt_o);
        end
        checks++;
        if (wr_q.size() != 58) begin
            errors++; $display("FAIL ovf_count: %0d writes, required 58", wr_q.size());
        end
        if (wr_q.size() > 4) begin
            checks++;
            if (wr_q[3].addr !== 32'h1180 || wr_q[4].addr !== 32'h1500) begin
                errors++; $display("FAIL ovf_gap: %h %h, required 00001180 00001500", wr_q[3].addr, wr_q[4].addr);
            end
        end
        for (int i = 0; i < wr_q.size() && i < 58; i++) begin
            slot  = (i < 4) ? i : i + 6;
            exp_a = 32'h1000 + 32'(slot) * 32'h80;
            checks++;
            if (wr_q[i].addr !== exp_a || wr_q[i].data !== row_data(3, slot)) begin
                errors++; $display("FAIL ovf_write[%0d]: addr %h data %h, required addr %h", i, wr_q[i].addr, wr_q[i].data[31:0], exp_a);
            end
        end
    endtask

    task automatic test_tag_mismatch();
        bit ok;
        logic [31:0] exp_a;
        clear_obs();
        do_cmd(8'd5, 32'h2000, 32'h40, ok);
        drive_tile(4, 8'd5, 64, 1, 1'b0, 0, 17, -1, 400);
        checks++;
        if (!ok || done_seen != 1 || {err_cnt_o, err_ovf_o, err_stray_o} !== 3'b100) begin
            errors++; $display("FAIL tag_flags: accepted %0d done %0d errs %b%b%b, required 1 1 100",
                               ok, done_seen, err_cnt_o, err_ovf_o, err_stray_o);
        end
        checks++;
        if (wr_q.size() != 64) begin
            errors++; $display("FAIL tag_count: %0d writes, required 64", wr_q.size());
        end
        if (wr_q.size() > 17) begin
            checks++;
            if (wr_q[17].addr !== 32'h2440 || wr_q[17].data !== row_data(4, 17)) begin
                errors++; $display("FAIL tag_row17: addr %h, required 00002440", wr_q[17].addr);
            end
        end
        for (int i = 0; i < wr_q.size() && i < 64; i++) begin
            exp_a = 32'h2000 + 32'(i) * 32'h40;
            checks++;
            if (wr_q[i].addr !== exp_a || wr_q[i].data !== row_data(4, i)) begin
                errors++; $display("FAIL tag_write[%0d]: addr %h, required %h", i, wr_q[i].addr, exp_a);
            end
        end
    endtask

    task automatic test_stray_and_cmd_block();
        bit ok;
        clear_obs();
        bot_valid_i = 1'b1; bot_cnt_i = 8'd5; bot_data_i = row_data(9, 0);
        @(posedge clk); #1;
        bot_valid_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (err_stray_o !== 1'b1 || wr_valid_o !== 1'b0) begin
            errors++; $display("FAIL stray_idle: stray %b wr_valid %b, required 1 0", err_stray_o, wr_valid_o);
        end
        do_cmd(8'd5, 32'h3000, 32'h20, ok);
        checks++;
        if (!ok || err_stray_o !== 1'b0) begin
            errors++; $display("FAIL stray_clear: accepted %0d stray %b, required 1 0", ok, err_stray_o);
        end
        // 65 rows: the last lands after the tile closes; a new cmd is held from row 20 on.
        drive_tile(5, 8'd5, 65, 1, 1'b0, 0, -1, 20, 400);
        checks++;
        if (done_seen != 1 || storec_seen != 1 || wr_q.size() != 64 || err_stray_o !== 1'b1) begin
            errors++; $display("FAIL stray_tile: done %0d storec %0d writes %0d stray %b, required 1 1 64 1",
                               done_seen, storec_seen, wr_q.size(), err_stray_o);
        end
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        checks++;
        if (storec_valid_o !== 1'b1) begin
            errors++; $display("FAIL stray_second_cmd: storec %b, required 1", storec_valid_o);
        end
        clear_obs();
        drive_tile(6, 8'd5, 64, 1, 1'b0, 0, -1, -1, 400);
        checks++;
        if (done_seen != 1 || wr_q.size() != 64 || err_stray_o !== 1'b0) begin
            errors++; $display("FAIL stray_second_tile: done %0d writes %0d stray %b, required 1 64 0", done_seen, wr_q.size(), err_stray_o);
        end
    endtask

    task automatic test_reset_mid_tile();
        bit ok;
        logic [31:0] exp_a;
        clear_obs();
        do_cmd(8'd5, 32'h4000_0000, 32'h100, ok);
        for (int k = 0; k < 30; k++) begin
            bot_valid_i = 1'b1;
            bot_cnt_i   = (k == 3) ? 8'd9 : 8'd5;
            bot_data_i  = row_data(7, k);
            @(posedge clk); #1;
        end
        bot_valid_i = 1'b1; bot_cnt_i = 8'd5; bot_data_i = row_data(7, 30);
        #2;
        checks++;
        if (!ok || err_cnt_o !== 1'b1 || wr_valid_o !== 1'b1) begin
            errors++; $display("FAIL midreset_pre: accepted %0d err_cnt %b wr_valid %b, required 1 1 1", ok, err_cnt_o, wr_valid_o);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready_o, storec_valid_o, wr_valid_o, wr_addr_o, wr_data_o, done_o, err_cnt_o, err_ovf_o, err_stray_o} !== '0) begin
            errors++; $display("FAIL midreset_outputs: ready %b wr_valid %b addr %h done %b errs %b%b%b, required all 0",
                               cmd_ready_o, wr_valid_o, wr_addr_o, done_o, err_cnt_o, err_ovf_o, err_stray_o);
        end
        bot_valid_i = 1'b0;
        clear_obs();
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_seen != 0 || wr_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
            errors++; $display("FAIL midreset_after: done %0d wr_valid %b ready %b, required 0 0 1", done_seen, wr_valid_o, cmd_ready_o);
        end
        // Base near the top of the address space so the tile wraps through zero.
        do_cmd(8'd5, 32'hFFFF_F000, 32'h80, ok);
        drive_tile(8, 8'd5, 64, 1, 1'b0, 0, -1, -1, 400);
        checks++;
        if (!ok || done_seen != 1 || wr_q.size() != 64 || {err_cnt_o, err_ovf_o, err_stray_o} !== 3'b000) begin
            errors++; $display("FAIL midreset_tile: accepted %0d done %0d writes %0d errs %b%b%b, required 1 1 64 000",
                               ok, done_seen, wr_q.size(), err_cnt_o, err_ovf_o, err_stray_o);
        end
        if (wr_q.size() == 64) begin
            checks++;
            if (wr_q[63].addr !== 32'h0000_0F80) begin
                errors++; $display("FAIL midreset_wrap: last addr %h, required 00000f80", wr_q[63].addr);
            end
        end
        for (int i = 0; i < wr_q.size() && i < 64; i++) begin
            exp_a = 32'hFFFF_F000 + 32'(i) * 32'h80;
            checks++;
            if (wr_q[i].addr !== exp_a || wr_q[i].data !== row_data(8, i)) begin
                errors++; $display("FAIL midreset_write[%0d]: addr %h, required %h", i, wr_q[i].addr, exp_a);
            end
        end
    endtask

    initial begin
        test_reset();
        @(posedge clk); #1;
        test_basic();
        test_throttled();
        test_overflow();
        test_tag_mismatch();
        test_stray_and_cmd_block();
        test_reset_mid_tile();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
